alu_operand_cond: RTL and testbench
===================================

Name: alu_operand_cond

Overview:
- Parametrised, registered operand-conditioning stage ahead of the ALU adder/logic unit in the pipelined datapath.
- Conditions two operands (X, Y) independently by a 2-bit mode each: pass, bitwise invert, two's-complement negate, force zero.
- Result is registered behind a valid/ready handshake with a 2-entry skid buffer, so ALU-side stalls never drop an operand pair.

Parameters:
- WIDTH, 16, operand width in bits (>=2).
- MODE_W, 2, width of each per-operand mode field (fixed at 2; exposed for the package).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers an operand pair.
- in_ready  out  1  stage can accept; registered.
- in_x  in  WIDTH  operand X.
- in_y  in  WIDTH  operand Y.
- in_mode_x  in  MODE_W  conditioning mode for X.
- in_mode_y  in  MODE_W  conditioning mode for Y.
- out_valid  out  1  conditioned pair available.
- out_ready  in  1  ALU accepts the pair.
- out_x  out  WIDTH  conditioned X.
- out_y  out  WIDTH  conditioned Y.
- out_ovf_x  out  1  X was negated from the most-negative value.
- out_ovf_y  out  1  Y was negated from the most-negative value.

Behaviour:
- Modes: 00 PASS (v), 01 INV (~v), 10 NEG (~v+1, modulo 2^WIDTH), 11 ZERO (0). Applied per operand, independently, combinationally, before the main register.
- ovf_x / ovf_y = 1 only for mode NEG with input 1 followed by WIDTH-1 zeros; the result wraps to the same value. 0 in all other cases.
- Storage: main register (drives outputs) plus skid register. Both hold {x, y, ovf_x, ovf_y} and a valid bit.
- Accept: in_valid & in_ready. Transfer: out_valid & out_ready.
- Latency: accepted pair appears on out_* the next cycle when main is empty or draining.
- in_ready = ~skid_valid, driven from a register, with no combinational path from out_ready.
- Accept with main empty or transferring: load main.
- Accept with main full and not transferring: load skid.
- Transfer with skid valid: main <= skid and skid is cleared. No accept is possible that cycle because in_ready = 0.
- Transfer with skid empty and no accept: main valid clears.
- Outputs are stable while out_valid & ~out_ready.
- Inputs are ignored when in_valid = 0 or in_ready = 0.
- Reset (any time, including mid-stall): all valid bits = 0, in_ready = 1, out_x = out_y = 0, ovf flags = 0. Any in-flight pairs are discarded.
- Throughput: one pair per cycle while out_ready is held high.

Optional Feature:
- Macro: ALU_OPCOND_NEG_EN.
- Defined: NEG mode implemented as above, with an internal WIDTH-bit incrementer.
- Not defined: mode 10 behaves as INV (~v), ovf flags are tied to 0, and no incrementer is instantiated. The ALU then supplies carry-in itself.

Decomposition:
- Shared package/include alu_opcond_pkg holds:
  - mode constants MODE_PASS=2'b00, MODE_INV=2'b01, MODE_NEG=2'b10, MODE_ZERO=2'b11;
  - MODE_W.
- One natural sub-module: alu_opcond_skid, a generic WIDTH-parametrised 2-entry skid buffer carrying the data and valid/ready. The top module holds the conditioning logic plus one instance of it.

Test Plan:
- Reset mid-stall: fill both entries with out_ready=0, assert rst → out_valid=0, in_ready=1, out_x=0, out_y=0 immediately (asynchronous); first pair after release is output cleanly.
- Modes, WIDTH=16, out_ready=1: X=0x1234, Y=0x00FF, modes PASS/INV → out_x=0x1234, out_y=0xFF00 one cycle later; then ZERO/NEG with Y=0x0001 → out_x=0x0000, out_y=0xFFFF.
- Negate boundary: in_y=0x8000, mode NEG → out_y=0x8000, out_ovf_y=1. Y=0x0000, NEG → 0x0000, ovf=0.
- Backpressure: send A, B, C back-to-back with out_ready=0 → A held on outputs, B in skid, in_ready=0 from the cycle after B, C not accepted; release out_ready → A, B, C delivered in order with none lost or duplicated.
- Streaming: 64 random pairs with in_valid=1 and out_ready=1 → one output per cycle after 1-cycle latency, matching the reference model.
- Macro off: mode NEG with Y=0x0005 → out_y=0xFFFA, out_ovf_y=0. Macro on: same stimulus → 0xFFFB.

Source files
------------

// File: rtl/alu_opcond_pkg.sv
// Shared definitions for the ALU operand-conditioning stage.
// Mode encoding for the per-operand conditioning field.
package alu_opcond_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_PASS = 2'b00;
    localparam logic [MODE_W-1:0] MODE_INV  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_NEG  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_ZERO = 2'b11;

    typedef enum logic [MODE_W-1:0] {
        OP_PASS = 2'b00,
        OP_INV  = 2'b01,
        OP_NEG  = 2'b10,
        OP_ZERO = 2'b11
    } opcond_mode_e;

endpackage : alu_opcond_pkg

// File: rtl/alu_opcond_skid.sv
// Generic 2-entry skid buffer (main + skid register) with valid/ready.
// in_ready is registered and depends only on the skid occupancy, so there
// is no combinational path from out_ready back to in_ready.
module alu_opcond_skid #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_reg, main_valid_next;
    logic [WIDTH-1:0] main_data_reg,  main_data_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
    logic             in_ready_reg,   in_ready_next;
    logic             accept;
    logic             xfer;

    assign accept = in_valid & in_ready_reg;
    assign xfer   = main_valid_reg & out_ready;

    // Next-state: skid refills main on transfer, otherwise route accepted data.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (xfer && skid_valid_reg) begin
            // in_ready is low whenever skid is occupied, so no accept here.
            main_data_next  = skid_data_reg;
            skid_valid_next = 1'b0;
        end else begin
            if (xfer) begin
                main_valid_next = 1'b0;
            end
            if (accept) begin
                if (!main_valid_reg || xfer) begin
                    main_valid_next = 1'b1;
                    main_data_next  = in_data;
                end else begin
                    skid_valid_next = 1'b1;
                    skid_data_next  = in_data;
                end
            end
        end
        in_ready_next = ~skid_valid_next;
    end

    // State registers; reset discards any in-flight entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule : alu_opcond_skid

// File: rtl/alu_operand_cond.sv
// Registered operand-conditioning stage ahead of the ALU.
// Each operand is independently passed, inverted, negated or zeroed, then
// registered through a 2-entry skid buffer.
// Optional feature macro: ALU_OPCOND_NEG_EN. When undefined, NEG mode
// behaves as INV (the ALU supplies the +1 as carry-in) and ovf flags are 0.
module alu_operand_cond #(
    parameter int WIDTH  = 16,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [MODE_W-1:0] in_mode_x,
    input  logic [MODE_W-1:0] in_mode_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_x,
    output logic [WIDTH-1:0]  out_y,
    output logic              out_ovf_x,
    output logic              out_ovf_y
);
    import alu_opcond_pkg::*;

    localparam int DW = 2 * WIDTH + 2;

    // Index 0 is X, index 1 is Y.
    logic [1:0][WIDTH-1:0]  opnd_all;
    logic [1:0][MODE_W-1:0] mode_all;
    logic [1:0][WIDTH-1:0]  cond_all;
    logic [1:0]             ovf_all;

    assign opnd_all = {in_y, in_x};
    assign mode_all = {in_mode_y, in_mode_x};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [WIDTH-1:0] cond_val;
            logic             cond_ovf;
`ifdef ALU_OPCOND_NEG_EN
            localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
            localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
            logic [WIDTH-1:0] neg_val;
            // Two's-complement negate through a WIDTH-bit incrementer.
            assign neg_val = ~opnd_all[gi] + ONE;
`endif

            // Per-operand conditioning selected by its mode field.
            always_comb begin
                cond_val = '0;
                cond_ovf = 1'b0;
                case (mode_all[gi])
                    MODE_PASS: cond_val = opnd_all[gi];
                    MODE_INV:  cond_val = ~opnd_all[gi];
                    MODE_NEG: begin
`ifdef ALU_OPCOND_NEG_EN
                        cond_val = neg_val;
                        cond_ovf = (opnd_all[gi] == MOST_NEG);
`else
                        cond_val = ~opnd_all[gi];
`endif
                    end
                    default:   cond_val = '0;
                endcase
            end

            assign cond_all[gi] = cond_val;
            assign ovf_all[gi]  = cond_ovf;
        end
    endgenerate

    logic [DW-1:0] skid_in_data;
    logic [DW-1:0] skid_out_data;

    assign skid_in_data = {cond_all[0], cond_all[1], ovf_all[0], ovf_all[1]};

    alu_opcond_skid #(
        .WIDTH (DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (skid_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out_data)
    );

    assign out_x     = skid_out_data[DW-1 -: WIDTH];
    assign out_y     = skid_out_data[WIDTH+1 -: WIDTH];
    assign out_ovf_x = skid_out_data[1];
    assign out_ovf_y = skid_out_data[0];

endmodule : alu_operand_cond

// File: tb/tb_alu_operand_cond.sv
// Directed testbench for alu_operand_cond (WIDTH=16).
module tb_alu_operand_cond;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [1:0]  in_mode_x;
    logic [1:0]  in_mode_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_ovf_x;
    logic        out_ovf_y;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    alu_operand_cond #(.WIDTH(16), .MODE_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode_x (in_mode_x),
        .in_mode_y (in_mode_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ovf_x (out_ovf_x),
        .out_ovf_y (out_ovf_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [1:0] mx, input logic [1:0] my);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_mode_x = mx;
        in_mode_y = my;
    endtask

    // Reference: returns {ovf, value}.
    function automatic logic [16:0] ref_cond(input logic [15:0] v, input logic [1:0] m);
        logic [15:0] t;
        case (m)
            2'b00: ref_cond = {1'b0, v};
            2'b01: ref_cond = {1'b0, ~v};
            2'b10: begin
`ifdef ALU_OPCOND_NEG_EN
                t = 16'd0 - v;
                ref_cond = {(v == 16'h8000), t};
`else
                t = ~v;
                ref_cond = {1'b0, t};
`endif
            end
            default: ref_cond = 17'd0;
        endcase
    endfunction

    logic [16:0] ex;
    logic [16:0] ey;
    logic [15:0] rx;
    logic [15:0] ry;
    logic [1:0]  rmx;
    logic [1:0]  rmy;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 2'b00);
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_x",     {48'd0, out_x},     64'd0);
        check("rst_out_y",     {48'd0, out_y},     64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Modes with out_ready held high.
        out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h00FF, 2'b00, 2'b01);
        step();
        $display("txn modes PASS/INV x=%h y=%h", out_x, out_y);
        check("pass_inv_valid", {63'd0, out_valid}, 64'd1);
        check("pass_x", {48'd0, out_x}, 64'h1234);
        check("inv_y",  {48'd0, out_y}, 64'hFF00);
        check("pass_inv_ovf", {62'd0, out_ovf_x, out_ovf_y}, 64'd0);

        drive(1'b1, 16'h1234, 16'h0001, 2'b11, 2'b10);
        step();
        $display("txn modes ZERO/NEG x=%h y=%h", out_x, out_y);
        check("zero_x", {48'd0, out_x}, 64'h0000);
`ifdef ALU_OPCOND_NEG_EN
        check("neg1_y", {48'd0, out_y}, 64'hFFFF);
`else
        check("neg1_y", {48'd0, out_y}, 64'hFFFE);
`endif

        // Negate boundary cases.
        drive(1'b1, 16'h0000, 16'h8000, 2'b00, 2'b10);
        step();
        $display("txn NEG 0x8000 y=%h ovf=%b", out_y, out_ovf_y);
`ifdef ALU_OPCOND_NEG_EN
        check("negmin_y",   {48'd0, out_y}, 64'h8000);
        check("negmin_ovf", {63'd0, out_ovf_y}, 64'd1);
`else
        check("negmin_y",   {48'd0, out_y}, 64'h7FFF);
        check("negmin_ovf", {63'd0, out_ovf_y}, 64'd0);
`endif

        drive(1'b1, 16'h8000, 16'h0000, 2'b10, 2'b10);
        step();
        $display("txn NEG 0x0000 y=%h ovf=%b", out_y, out_ovf_y);
`ifdef ALU_OPCOND_NEG_EN
        check("neg0_y",   {48'd0, out_y}, 64'h0000);
        check("neg0_x",   {48'd0, out_x}, 64'h8000);
        check("neg0_ovfx", {63'd0, out_ovf_x}, 64'd1);
`else
        check("neg0_y",   {48'd0, out_y}, 64'hFFFF);
        check("neg0_x",   {48'd0, out_x}, 64'h7FFF);
        check("neg0_ovfx", {63'd0, out_ovf_x}, 64'd0);
`endif
        check("neg0_ovfy", {63'd0, out_ovf_y}, 64'd0);

        drive(1'b1, 16'h0000, 16'h0005, 2'b00, 2'b10);
        step();
        $display("txn NEG 0x0005 y=%h", out_y);
`ifdef ALU_OPCOND_NEG_EN
        check("neg5_y", {48'd0, out_y}, 64'hFFFB);
`else
        check("neg5_y", {48'd0, out_y}, 64'hFFFA);
`endif
        check("neg5_ovf", {63'd0, out_ovf_y}, 64'd0);

        drive(1'b0, 16'h0, 16'h0, 2'b00, 2'b00);
        step();
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: A, B, C back-to-back with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 16'h0A0A, 2'b00, 2'b00);
        step();
        $display("txn bp A x=%h in_ready=%b", out_x, in_ready);
        check("bpA_x", {48'd0, out_x}, 64'hAAAA);
        check("bpA_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 16'hBBBB, 16'h0B0B, 2'b00, 2'b00);
        step();
        $display("txn bp B x=%h in_ready=%b", out_x, in_ready);
        check("bpB_hold_x", {48'd0, out_x}, 64'hAAAA);
        check("bpB_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 16'hCCCC, 16'h0C0C, 2'b00, 2'b00);
        step();
        $display("txn bp C x=%h in_ready=%b", out_x, in_ready);
        check("bpC_hold_x", {48'd0, out_x}, 64'hAAAA);
        check("bpC_hold_y", {48'd0, out_y}, 64'h0A0A);
        check("bpC_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        step();
        $display("txn bp release x=%h y=%h", out_x, out_y);
        check("bp_out_B", {47'd0, out_valid, out_x}, {47'd0, 1'b1, 16'hBBBB});
        check("bp_ready_back", {63'd0, in_ready}, 64'd1);
        step();
        $display("txn bp next x=%h y=%h", out_x, out_y);
        check("bp_out_C", {31'd0, out_valid, out_x, out_y}, {31'd0, 1'b1, 16'hCCCC, 16'h0C0C});
        drive(1'b0, 16'h0, 16'h0, 2'b00, 2'b00);
        step();
        check("bp_no_dup", {63'd0, out_valid}, 64'd0);

        // Streaming: one random pair per cycle.
        for (int i = 0; i < 64; i++) begin
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            rmx = 2'($urandom_range(0, 3));
            rmy = 2'($urandom_range(0, 3));
            drive(1'b1, rx, ry, rmx, rmy);
            ex = ref_cond(rx, rmx);
            ey = ref_cond(ry, rmy);
            step();
            $display("txn stream %0d x=%h y=%h", i, out_x, out_y);
            check("stream", {29'd0, out_valid, in_ready, out_ovf_x, out_ovf_y, out_x, out_y},
                  {29'd0, 1'b1, 1'b1, ex[16], ey[16], ex[15:0], ey[15:0]});
        end

        // Reset during a full stall.
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h2222, 2'b00, 2'b00);
        step();
        drive(1'b1, 16'h3333, 16'h4444, 2'b00, 2'b00);
        step();
        drive(1'b0, 16'h0, 16'h0, 2'b00, 2'b00);
        check("stall_full_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        $display("txn async reset valid=%b ready=%b", out_valid, in_ready);
        check("arst_state", {30'd0, out_valid, in_ready, out_x, out_y},
              {30'd0, 1'b0, 1'b1, 16'h0, 16'h0});
        check("arst_ovf", {62'd0, out_ovf_x, out_ovf_y}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 16'h5A5A, 16'hA5A5, 2'b01, 2'b00);
        step();
        $display("txn post-reset x=%h y=%h", out_x, out_y);
        check("post_rst_pair", {31'd0, out_valid, out_x, out_y}, {31'd0, 1'b1, 16'hA5A5, 16'hA5A5});
        drive(1'b0, 16'h0, 16'h0, 2'b00, 2'b00);
        step();
        check("post_rst_drain", {63'd0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_alu_operand_cond
